vector_dac_streamer: RTL
========================

Name: vector_dac_streamer

Overview:
Buffers a stream of X/Y points in an internal FIFO and plays them out to a dual-channel MCP4922-class SPI DAC. X goes to channel A and Y to channel B. Both channels are latched together with an LDAC pulse, so the beam never sees a half-updated point. A configurable dwell follows each point. The block sits between a point generator (line drawer, test pattern) and the DAC pins, replacing the single-value-per-strobe DAC driver.

Parameters:
BITS, 12, sample width per axis; legal range 1..12; values narrower than 12 are left-justified with zero LSB padding.
DEPTH, 16, FIFO depth in points; power of 2, >= 2.
CLK_DIV, 4, SPI half-period in clk cycles; >= 1.
HOLD, 0, dwell cycles after each LDAC pulse; >= 0.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset (asserted when 0).
in_x  in  BITS  X sample.
in_y  in  BITS  Y sample.
in_valid  in  1  point offered.
in_ready  out  1  FIFO can accept a point; equals !full.
level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
busy  out  1  serializer is not in IDLE.
underflow  out  1  one-cycle pulse: a point finished and the FIFO was empty.
cs_pin  out  1  DAC chip select, active low.
clk_pin  out  1  SPI clock, idle low.
data_pin  out  1  SPI data, MSB first.
ldac_pin  out  1  DAC latch, active low.

Behaviour:
- Reset values (asynchronous): cs_pin=1, clk_pin=0, data_pin=0, ldac_pin=1, busy=0, underflow=0, level=0, in_ready=1. FIFO is flushed and the serializer goes to IDLE.
- Reset asserted mid-frame: pins return to idle immediately; no partial frame is resumed after release.
- Push: a point is written when in_valid && in_ready at a clk edge.
- Pop: a point is read only on the IDLE->LOAD transition. X and Y are latched into internal registers at that edge.
- Push while full is refused because in_ready=0; there is no overwrite.
- Simultaneous push and pop (not full): level is unchanged.
- Pop while full: in_ready rises the cycle after the pop.
- FIFO pointers wrap modulo DEPTH. Full/empty are distinguished by the extra level bit.
- Frame format (16 bits, MSB first):
  - bit15 = channel (0=A/X, 1=B/Y)
  - bit14 = BUF = 0
  - bit13 = GA_n = 1
  - bit12 = SHDN_n = 1
  - bits11..0 = sample << (12-BITS)
- States:
  - IDLE: FIFO non-empty -> LOAD_X; otherwise stay.
  - LOAD_X / LOAD_Y: 1 cycle. cs_pin=0, data_pin=frame bit15. -> SHIFT.
  - SHIFT: 16 bits. Each bit holds clk_pin=0 for CLK_DIV cycles, then clk_pin=1 for CLK_DIV cycles. data_pin changes only while clk_pin=0, on the cycle clk_pin falls or at LOAD. After bit0 high phase: clk_pin=0, -> GAP.
  - GAP: cs_pin=1 for CLK_DIV cycles. After the X frame -> LOAD_Y; after the Y frame -> LDAC.
  - LDAC: ldac_pin=0 for CLK_DIV cycles. -> DWELL if HOLD>0, else END.
  - DWELL: HOLD cycles, all pins idle. -> END.
  - END: 1 cycle. If the FIFO is empty, pulse underflow. -> IDLE.
- Cycles per point from LOAD_X to END inclusive: 2*(1+33*CLK_DIV) + CLK_DIV + HOLD + 1. With defaults (CLK_DIV=4, HOLD=0) this is 271.
- Back-to-back points: a full FIFO streams one point every (cycles per point + 1) cycles, with the +1 for IDLE.
- ldac_pin is never low while cs_pin is low.
- busy = (state != IDLE).

Test Plan:
- Reset check: hold reset=0 for 5 cycles with in_valid=1 -> cs_pin=1, clk_pin=0, ldac_pin=1, level=0, no pop. After release, in_ready=1.
- Single point, defaults: push X=0xABC, Y=0x123.
  - Frame 1 sampled on clk_pin rising edges = 0x3ABC; frame 2 = 0xB123.
  - ldac_pin low for exactly 4 cycles after the second cs_pin rise.
  - underflow pulses once; 271 cycles from LOAD_X to END.
- Width padding, BITS=8: push X=0xFF, Y=0x01 -> frames 0x3FF0 and 0xB010.
- Fill, DEPTH=4: push 6 points continuously while the serializer is busy.
  - in_ready=0 at level=4; exactly 5 points accepted (one popped during filling).
  - Output order matches input; no underflow until the last point ends.
- Dwell, HOLD=10, CLK_DIV=1: two queued points -> LDAC-fall-to-next-cs_pin-fall spacing = 1+10+1+1 = 13 cycles. cs_pin stays high throughout the dwell.
- Reset mid-operation: drop reset during SHIFT bit 7 of the Y frame -> pins idle the same cycle, level=0. After release, no frame appears until a new push.

Source files
------------

// File: rtl/vector_dac_streamer.sv
`timescale 1ns/1ps
// vector_dac_streamer: FIFO-buffered X/Y point player for a dual-channel
// MCP4922-class SPI DAC; both channels are latched together by an LDAC pulse.
module vector_dac_streamer #(
  parameter int unsigned BITS    = 12,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned HOLD    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BITS-1:0]          in_x,
  input  logic [BITS-1:0]          in_y,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     underflow,
  output logic                     cs_pin,
  output logic                     clk_pin,
  output logic                     data_pin,
  output logic                     ldac_pin
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned CMAX = (HOLD > CLK_DIV) ? HOLD : CLK_DIV;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD > 0) ? HOLD - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_X, S_LOAD_Y, S_SHIFT, S_GAP, S_LDAC, S_DWELL, S_END
  } state_t;

  // Command word: channel, BUF=0, GA_n=1, SHDN_n=1, left-justified sample.
  function automatic logic [15:0] mk_frame(input logic ch, input logic [BITS-1:0] s);
    logic [11:0] v;
    v = 12'(s) << (12 - BITS);
    return {ch, 3'b011, v};
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [BITS-1:0] mem_x [DEPTH];
  logic [BITS-1:0] mem_y [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, empty, push, pop;
  logic [BITS-1:0] rd_x, rd_y;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign rd_x     = mem_x[rd_ptr];
  assign rd_y     = mem_y[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr] <= in_x;
      mem_y[wr_ptr] <= in_y;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------- serializer
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      bit_cnt, bit_n;
  logic            sclk, sclk_n;
  logic            chan_y, chan_n;
  logic [15:0]     sr, sr_n;
  logic [BITS-1:0] y_lat, y_n;
  logic            frame_on;
  logic            cs_n, clk_n, data_n, ldac_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    sclk_n  = sclk;
    chan_n  = chan_y;
    sr_n    = sr;
    y_n     = y_lat;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          y_n     = rd_y;
          sr_n    = mk_frame(1'b0, rd_x);
          chan_n  = 1'b0;
          state_n = S_LOAD_X;
        end
      end
      S_LOAD_X, S_LOAD_Y: begin
        cnt_n   = '0;
        bit_n   = 4'd15;
        sclk_n  = 1'b0;
        state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_n = '0;
          if (!sclk) begin
            sclk_n = 1'b1;
          end else begin
            // Falling edge: next bit goes out while the clock is low.
            sclk_n = 1'b0;
            if (bit_cnt == 4'd0) begin
              state_n = S_GAP;
            end else begin
              bit_n = bit_cnt - 4'd1;
              sr_n  = {sr[14:0], 1'b0};
            end
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == DIV_LAST) begin
          cnt_n = '0;
          if (chan_y) begin
            state_n = S_LDAC;
          end else begin
            chan_n  = 1'b1;
            sr_n    = mk_frame(1'b1, y_lat);
            state_n = S_LOAD_Y;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_LDAC: begin
        if (cnt == DIV_LAST) begin
          cnt_n   = '0;
          state_n = (HOLD > 0) ? S_DWELL : S_END;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DWELL: begin
        if (cnt == HOLD_LAST) begin
          cnt_n   = '0;
          state_n = S_END;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_END:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Pins are registered from the next state so they track it glitch-free.
    frame_on = (state_n == S_LOAD_X) || (state_n == S_LOAD_Y) || (state_n == S_SHIFT);
    cs_n     = !frame_on;
    clk_n    = (state_n == S_SHIFT) && sclk_n;
    data_n   = frame_on ? sr_n[15] : 1'b0;
    ldac_n   = (state_n != S_LDAC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sclk     <= 1'b0;
      chan_y   <= 1'b0;
      sr       <= '0;
      y_lat    <= '0;
      cs_pin   <= 1'b1;
      clk_pin  <= 1'b0;
      data_pin <= 1'b0;
      ldac_pin <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      sclk     <= sclk_n;
      chan_y   <= chan_n;
      sr       <= sr_n;
      y_lat    <= y_n;
      cs_pin   <= cs_n;
      clk_pin  <= clk_n;
      data_pin <= data_n;
      ldac_pin <= ldac_n;
    end
  end

  assign busy      = (state != S_IDLE);
  assign underflow = (state == S_END) && empty;

endmodule
